// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: operand defaults,
// feeder state encoding and a lane extraction helper.
package systolic_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned MAX_LANES  = 16;
    localparam int unsigned LANE_VEC_W = MAX_LANES * DATA_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Extract lane i from a flat lane vector (zero-extend narrower vectors first).
    function automatic logic [DATA_W_DEF-1:0] lane_slice(input logic [LANE_VEC_W-1:0] vec,
                                                         input int unsigned i);
        return vec[i*DATA_W_DEF +: DATA_W_DEF];
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_buf.sv
// skew_tile_buf: K_MAX-deep tile store, one full k-step written per beat,
// one independent combinational read port per lane.
module skew_tile_buf
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned K_MAX  = 16
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(K_MAX)-1:0]      wr_addr,
    input  logic [N*DATA_W-1:0]           wr_data,
    input  logic [N*$clog2(K_MAX)-1:0]    rd_addr,
    output logic [N*DATA_W-1:0]           rd_data_c
);

    localparam int unsigned AW    = $clog2(K_MAX);
    localparam int unsigned VEC_W = N * DATA_W;

    logic [VEC_W-1:0] mem [K_MAX];

    // Plain register file: contents are only meaningful once a tile is loaded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rd
        assign rd_data_c[i*DATA_W +: DATA_W] = mem[rd_addr[i*AW +: AW]][i*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one tile of row-operand k-steps, then replays it into the array's
// left edge with lane i delayed by i cycles (diagonal skew).
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned K_MAX  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N*DATA_W-1:0] s_data,
    input  logic                s_last,
    output logic [N-1:0]        pe_valid,
    output logic [N*DATA_W-1:0] pe_data,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned AW    = $clog2(K_MAX);
    localparam int unsigned PTR_W = $clog2(K_MAX) + 1;
    localparam int unsigned T_W   = $clog2(K_MAX + N) + 1;
    localparam int unsigned VEC_W = N * DATA_W;

    feeder_state_e    state, state_d;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0] k_len, k_len_d;
    logic [T_W-1:0]   t, t_d;
    logic [T_W-1:0]   t_last_c;
    logic [N-1:0]     pe_valid_d;
    logic [VEC_W-1:0] pe_data_d;
    logic             done_d;
    logic             overflow_d;

    logic             xfer_c;
    logic [AW-1:0]    wr_addr_c;
    logic [N*AW-1:0]  rd_addr_c;
    logic [VEC_W-1:0] rd_data_c;

    assign s_ready   = (state == ST_IDLE) || (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign xfer_c    = s_valid && s_ready;
    assign wr_addr_c = (state == ST_IDLE) ? '0 : wr_ptr[AW-1:0];
    assign t_last_c  = T_W'(k_len) + T_W'(N) - T_W'(2);

    // Lane i reads k-step t-i; out-of-range addresses are masked below.
    always_comb begin
        rd_addr_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rd_addr_c[i*AW +: AW] = AW'(t - T_W'(i));
        end
    end

    skew_tile_buf #(
        .N      (N),
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX)
    ) u_buf (
        .clk       (clk),
        .wr_en     (xfer_c),
        .wr_addr   (wr_addr_c),
        .wr_data   (s_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        wr_ptr_d   = wr_ptr;
        k_len_d    = k_len;
        t_d        = t;
        pe_valid_d = '0;
        pe_data_d  = '0;
        done_d     = 1'b0;
        overflow_d = 1'b0;

        case (state)
            ST_IDLE: begin
                if (xfer_c) begin
                    wr_ptr_d = PTR_W'(1);
                    if (s_last) begin
                        k_len_d = PTR_W'(1);
                        t_d     = '0;
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer_c) begin
                    wr_ptr_d = wr_ptr + PTR_W'(1);
                    if (s_last) begin
                        k_len_d = wr_ptr + PTR_W'(1);
                        t_d     = '0;
                        state_d = ST_STREAM;
                    end else if (wr_ptr == PTR_W'(K_MAX - 1)) begin
                        // Tile full without s_last: truncate, later beats start a new tile.
                        k_len_d    = PTR_W'(K_MAX);
                        overflow_d = 1'b1;
                        t_d        = '0;
                        state_d    = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                t_d = t + T_W'(1);
                for (int unsigned i = 0; i < N; i++) begin
                    if ((t >= T_W'(i)) && ((t - T_W'(i)) < T_W'(k_len))) begin
                        pe_valid_d[i]                 = 1'b1;
                        pe_data_d[i*DATA_W +: DATA_W] = rd_data_c[i*DATA_W +: DATA_W];
                    end
                end
                if (t == t_last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                wr_ptr_d = '0;
                t_d      = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            k_len    <= '0;
            t        <= '0;
            pe_valid <= '0;
            pe_data  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            wr_ptr   <= wr_ptr_d;
            k_len    <= k_len_d;
            t        <= t_d;
            pe_valid <= pe_valid_d;
            pe_data  <= pe_data_d;
            done     <= done_d;
            overflow <= overflow_d;
        end
    end

endmodule
